// File: rtl/regfile_pkg.sv
// Shared constants and address type for the 32-entry register file.
package regfile_pkg;

    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/mux32.sv
// Generic 32:1 select mux shared by the operand read paths.
module mux32
    import regfile_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] in [REG_COUNT],
    input  reg_addr_t    sel,
    output logic [N-1:0] out
);

    assign out = in[sel];

endmodule

// File: rtl/register_en.sv
// One N-bit storage register with synchronous active-high clear and load enable.
module register_en #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Clear wins over load so a write in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x N register file, x0 hardwired to zero, one synchronous write port, two combinational reads.
// Defining REGFILE_BYPASS_EN forwards an in-flight write to a matching read port in the same cycle.
module register_file
    import regfile_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  reg_addr_t    wr_addr,
    input  logic [N-1:0] wr_data,
    input  reg_addr_t    rd_addr0,
    input  reg_addr_t    rd_addr1,
    output logic [N-1:0] rd_data0,
    output logic [N-1:0] rd_data1
);

    logic [N-1:0] regs [REG_COUNT];
    logic [N-1:0] mux_out0;
    logic [N-1:0] mux_out1;

    // x0 has no storage; the mux input is simply tied low.
    assign regs[0] = '0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
        logic ena;

        assign ena = wr_ena & (wr_addr == reg_addr_t'(i));

        register_en #(
            .N (N)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .ena (ena),
            .d   (wr_data),
            .q   (regs[i])
        );
    end

    mux32 #(
        .N (N)
    ) u_mux0 (
        .in  (regs),
        .sel (rd_addr0),
        .out (mux_out0)
    );

    mux32 #(
        .N (N)
    ) u_mux1 (
        .in  (regs),
        .sel (rd_addr1),
        .out (mux_out1)
    );

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    logic byp0;
    logic byp1;

    // Forwarding is blocked for x0 and while reset is held, so reads show stored values then.
    assign wr_live  = wr_ena & ~rst & (wr_addr != ZERO_REG);
    assign byp0     = wr_live & (rd_addr0 == wr_addr);
    assign byp1     = wr_live & (rd_addr1 == wr_addr);
    assign rd_data0 = byp0 ? wr_data : mux_out0;
    assign rd_data1 = byp1 ? wr_data : mux_out1;
`else
    assign rd_data0 = mux_out0;
    assign rd_data1 = mux_out1;
`endif

endmodule
